// File: rtl/multi_cycle_execute_stage4.sv
// ---------------------------------------------------------------------------
// multi_cycle_execute_stage4
//
// Fourth stage of the multi-cycle floating-point execute pipeline. It
// normalizes the per-lane adder sums and multiplier products produced by
// stage 3. Every output is registered, with one cycle of latency. There is no
// backpressure.
//
// Add path (per lane):
//   - carry out:   shift right by one and increment the exponent.
//   - no carry:    leading-zero normalize, subtracting lz from the exponent.
//   - exact zero:  signed zero.
//   - underflow:   denormal or flush-to-zero result, chosen at build time.
// Mul path (per lane): one-bit normalize, then truncate. Exponent overflow
// saturates to 8'hFF with a zero significand.
//
// Build option:
//   FP_FLUSH_TO_ZERO_EN  defined   -> add underflow flushes to signed zero.
//                        undefined -> add underflow produces a denormal.
//
// Ports (all per-lane buses are flat, lane n at [n*W +: W]):
//   clk, reset                         clock, async active-low reset
//   mx3_instruction_valid/instruction/mask_value/thread_idx/subcycle
//   mx3_result_is_inf/nan              control, passed through to mx4_*
//   mx3_sum(25)/add_exponent(8)/add_result_sign/logical_subtract
//                                      adder inputs
//   mx3_significand_product(48)/mul_exponent(8)/mul_sign
//                                      multiplier inputs
//   mx4_add_significand(23)/add_exponent(8)/add_sign/add_zero/add_overflow
//   mx4_mul_significand(23)/mul_exponent(8)/mul_sign/mul_overflow
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module multi_cycle_execute_stage4 #(
  parameter int VECTOR_LANES     = 16,
  parameter int INSTR_WIDTH      = 32,
  parameter int THREAD_IDX_WIDTH = 2,
  parameter int SUBCYCLE_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mx3_instruction_valid,
  input  logic [INSTR_WIDTH-1:0]         mx3_instruction,
  input  logic [VECTOR_LANES-1:0]        mx3_mask_value,
  input  logic [THREAD_IDX_WIDTH-1:0]    mx3_thread_idx,
  input  logic [SUBCYCLE_WIDTH-1:0]      mx3_subcycle,
  input  logic [VECTOR_LANES-1:0]        mx3_result_is_inf,
  input  logic [VECTOR_LANES-1:0]        mx3_result_is_nan,
  input  logic [VECTOR_LANES*25-1:0]     mx3_sum,
  input  logic [VECTOR_LANES*8-1:0]      mx3_add_exponent,
  input  logic [VECTOR_LANES-1:0]        mx3_add_result_sign,
  input  logic [VECTOR_LANES-1:0]        mx3_logical_subtract,
  input  logic [VECTOR_LANES*48-1:0]     mx3_significand_product,
  input  logic [VECTOR_LANES*8-1:0]      mx3_mul_exponent,
  input  logic [VECTOR_LANES-1:0]        mx3_mul_sign,
  output logic                           mx4_instruction_valid,
  output logic [INSTR_WIDTH-1:0]         mx4_instruction,
  output logic [VECTOR_LANES-1:0]        mx4_mask_value,
  output logic [THREAD_IDX_WIDTH-1:0]    mx4_thread_idx,
  output logic [SUBCYCLE_WIDTH-1:0]      mx4_subcycle,
  output logic [VECTOR_LANES-1:0]        mx4_result_is_inf,
  output logic [VECTOR_LANES-1:0]        mx4_result_is_nan,
  output logic [VECTOR_LANES*23-1:0]     mx4_add_significand,
  output logic [VECTOR_LANES*8-1:0]      mx4_add_exponent,
  output logic [VECTOR_LANES-1:0]        mx4_add_sign,
  output logic [VECTOR_LANES-1:0]        mx4_add_zero,
  output logic [VECTOR_LANES-1:0]        mx4_add_overflow,
  output logic [VECTOR_LANES*23-1:0]     mx4_mul_significand,
  output logic [VECTOR_LANES*8-1:0]      mx4_mul_exponent,
  output logic [VECTOR_LANES-1:0]        mx4_mul_sign,
  output logic [VECTOR_LANES-1:0]        mx4_mul_overflow
);

  // Leading-zero count of a 24-bit value. The scan runs upward, so the
  // highest set bit decides the count. A zero input is never normalized.
  function automatic logic [4:0] lead_zeros24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd23;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'd23 - 5'(i);
      else      n = n;
    end
    return n;
  endfunction

  // One lane of add normalization. Returns {sig[22:0], exp[7:0], sign, zero, overflow}.
  function automatic logic [33:0] add_lane(input logic [24:0] sum,
                                           input logic [7:0]  exp_in,
                                           input logic        res_sign,
                                           input logic        lsub);
    logic [22:0] sig;
    logic [7:0]  e;
    logic        sgn;
    logic        zero;
    logic        ovf;
    logic [8:0]  exp_inc;
    logic [4:0]  lz;
    logic [23:0] shifted;
    sig     = 23'd0;
    e       = 8'd0;
    sgn     = res_sign;
    zero    = 1'b0;
    ovf     = 1'b0;
    shifted = 24'd0;
    exp_inc = {1'b0, exp_in} + 9'd1;
    lz      = lead_zeros24(sum[23:0]);
    if (sum[24]) begin
      if (exp_inc >= 9'd255) begin
        ovf = 1'b1;
        e   = 8'hFF;
      end else begin
        sig = sum[23:1];
        e   = exp_inc[7:0];
      end
    end else if (sum[23:0] == 24'd0) begin
      // A true cancellation rounds to +0. An add of two zeros keeps its sign.
      zero = 1'b1;
      sgn  = lsub ? 1'b0 : res_sign;
    end else if (exp_in <= {3'd0, lz}) begin
      // Full normalization would drive the exponent to zero or below.
`ifdef FP_FLUSH_TO_ZERO_EN
      zero = 1'b1;
`else
      // exp_in <= 23 here, so the low five bits hold the whole shift amount.
      shifted = sum[23:0] << ((exp_in == 8'd0) ? 5'd0 : (exp_in[4:0] - 5'd1));
      sig     = shifted[22:0];
`endif
    end else begin
      shifted = sum[23:0] << lz;
      sig     = shifted[22:0];
      e       = exp_in - {3'd0, lz};
    end
    return {sig, e, sgn, zero, ovf};
  endfunction

  // One lane of multiply normalization from product[47:23]. Returns {sig[22:0], exp[7:0], overflow}.
  function automatic logic [31:0] mul_lane(input logic [24:0] prod_hi,
                                           input logic [7:0]  exp_in);
    logic [22:0] sig;
    logic [8:0]  e9;
    logic        ovf;
    if (prod_hi[24]) begin
      sig = prod_hi[23:1];
      e9  = {1'b0, exp_in} + 9'd1;
    end else begin
      sig = prod_hi[22:0];
      e9  = {1'b0, exp_in};
    end
    if (e9 >= 9'd255) begin
      ovf = 1'b1;
      e9  = 9'h0FF;
      sig = 23'd0;
    end else begin
      ovf = 1'b0;
    end
    return {sig, e9[7:0], ovf};
  endfunction

  logic [VECTOR_LANES*23-1:0] add_sig_s;
  logic [VECTOR_LANES*8-1:0]  add_exp_s;
  logic [VECTOR_LANES-1:0]    add_sign_s;
  logic [VECTOR_LANES-1:0]    add_zero_s;
  logic [VECTOR_LANES-1:0]    add_ovf_s;
  logic [VECTOR_LANES*23-1:0] mul_sig_s;
  logic [VECTOR_LANES*8-1:0]  mul_exp_s;
  logic [VECTOR_LANES-1:0]    mul_ovf_s;
  logic                       unused_prod_s;

  // Per-lane add and multiply normalization for the next register values.
  always_comb begin
    logic [33:0] add_res;
    logic [31:0] mul_res;
    add_res       = 34'd0;
    mul_res       = 32'd0;
    add_sig_s     = {(VECTOR_LANES*23){1'b0}};
    add_exp_s     = {(VECTOR_LANES*8){1'b0}};
    add_sign_s    = {VECTOR_LANES{1'b0}};
    add_zero_s    = {VECTOR_LANES{1'b0}};
    add_ovf_s     = {VECTOR_LANES{1'b0}};
    mul_sig_s     = {(VECTOR_LANES*23){1'b0}};
    mul_exp_s     = {(VECTOR_LANES*8){1'b0}};
    mul_ovf_s     = {VECTOR_LANES{1'b0}};
    unused_prod_s = 1'b0;
    for (int lane = 0; lane < VECTOR_LANES; lane++) begin
      add_res = add_lane(mx3_sum[lane*25 +: 25], mx3_add_exponent[lane*8 +: 8],
                         mx3_add_result_sign[lane], mx3_logical_subtract[lane]);
      add_sig_s[lane*23 +: 23] = add_res[33:11];
      add_exp_s[lane*8 +: 8]   = add_res[10:3];
      add_sign_s[lane]         = add_res[2];
      add_zero_s[lane]         = add_res[1];
      add_ovf_s[lane]          = add_res[0];
      mul_res = mul_lane(mx3_significand_product[lane*48+23 +: 25],
                         mx3_mul_exponent[lane*8 +: 8]);
      mul_sig_s[lane*23 +: 23] = mul_res[31:9];
      mul_exp_s[lane*8 +: 8]   = mul_res[8:1];
      mul_ovf_s[lane]          = mul_res[0];
      // Product bits below the result are dropped, since this stage truncates.
      unused_prod_s = unused_prod_s ^ (^mx3_significand_product[lane*48 +: 23]);
    end
  end

  // Stage register. Reset clears it at once, which drops any in-flight group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mx4_instruction_valid <= 1'b0;
      mx4_instruction       <= {INSTR_WIDTH{1'b0}};
      mx4_mask_value        <= {VECTOR_LANES{1'b0}};
      mx4_thread_idx        <= {THREAD_IDX_WIDTH{1'b0}};
      mx4_subcycle          <= {SUBCYCLE_WIDTH{1'b0}};
      mx4_result_is_inf     <= {VECTOR_LANES{1'b0}};
      mx4_result_is_nan     <= {VECTOR_LANES{1'b0}};
      mx4_add_significand   <= {(VECTOR_LANES*23){1'b0}};
      mx4_add_exponent      <= {(VECTOR_LANES*8){1'b0}};
      mx4_add_sign          <= {VECTOR_LANES{1'b0}};
      mx4_add_zero          <= {VECTOR_LANES{1'b0}};
      mx4_add_overflow      <= {VECTOR_LANES{1'b0}};
      mx4_mul_significand   <= {(VECTOR_LANES*23){1'b0}};
      mx4_mul_exponent      <= {(VECTOR_LANES*8){1'b0}};
      mx4_mul_sign          <= {VECTOR_LANES{1'b0}};
      mx4_mul_overflow      <= {VECTOR_LANES{1'b0}};
    end else begin
      mx4_instruction_valid <= mx3_instruction_valid;
      mx4_instruction       <= mx3_instruction;
      mx4_mask_value        <= mx3_mask_value;
      mx4_thread_idx        <= mx3_thread_idx;
      mx4_subcycle          <= mx3_subcycle;
      mx4_result_is_inf     <= mx3_result_is_inf;
      mx4_result_is_nan     <= mx3_result_is_nan;
      mx4_add_significand   <= add_sig_s;
      mx4_add_exponent      <= add_exp_s;
      mx4_add_sign          <= add_sign_s;
      mx4_add_zero          <= add_zero_s;
      mx4_add_overflow      <= add_ovf_s;
      mx4_mul_significand   <= mul_sig_s;
      mx4_mul_exponent      <= mul_exp_s;
      mx4_mul_sign          <= mx3_mul_sign;
      mx4_mul_overflow      <= mul_ovf_s;
    end
  end

endmodule
